// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and address decode for the APB master arbiter
//
// Purpose : FSM state encoding and slave-index decode used by apb_master_arbiter.
// Contents: apb_state_t  - IDLE / SETUP / ACCESS
//           slv_idx()    - top sel_w bits of an address_w-wide address
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  // addr is zero-extended to 32 bits by the caller; addr_w is the real width.
  function automatic int unsigned slv_idx(input logic [31:0] addr,
                                          input int unsigned addr_w,
                                          input int unsigned sel_w);
    logic [31:0] w_shift;
    w_shift = addr >> (addr_w - sel_w);
    return w_shift & ((32'd1 << sel_w) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose : picks the first asserted request starting at index ptr and
//           wrapping around; one-hot result, all zeros when nothing requests.
// Ports   : req [N]      request vector
//           ptr [PTR_W]  index where the search starts
//           gnt [N]      one-hot grant
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic w_found;
  int   w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(ptr) + i) % N;
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master shared by N_REQ requesters
//
// Purpose : arbitrates requesters round robin and runs each winner as one APB
//           transfer (SETUP, ACCESS stretched by pready), with a timeout abort.
// Ports   : clk, reset_n                  clock, async active-low reset
//           req_valid/write/addr/wdata    packed per-requester request inputs
//           req_gnt                       1-cycle pulse when a request is latched
//           rsp_done/rsp_rdata/rsp_err    completion pulse to owner, data, timeout flag
//           paddr/pwrite/psel/penable/pwdata/prdata/pready   APB master side
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int N_SLV   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_gnt,
  output logic [N_REQ-1:0]          rsp_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [N_SLV-1:0]          psel,
  output logic                      penable,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int SEL_W = $clog2(N_SLV);
  localparam int CNT_W = $clog2(TIMEOUT);

  apb_state_t        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_REQ-1:0]  r_owner;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [N_SLV-1:0]  r_psel;
  logic              r_penable;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [N_REQ-1:0]  w_gnt;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_next_ptr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [N_SLV-1:0]  w_psel;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_idx = PTR_W'(i);
    end
  end

  // N_REQ need not be a power of two, so wrap explicitly.
  assign w_next_ptr = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
  assign w_addr     = req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_wdata    = req_wdata[w_idx*DATA_W +: DATA_W];
  assign w_psel     = N_SLV'(1) << slv_idx(32'(w_addr), ADDR_W, SEL_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= APB_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_owner   <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        APB_IDLE: begin
          if (|req_valid) begin
            r_paddr  <= w_addr;
            r_pwrite <= req_write[w_idx];
            r_pwdata <= w_wdata;
            r_psel   <= w_psel;
            r_gnt    <= w_gnt;
            r_owner  <= w_gnt;
            r_ptr    <= w_next_ptr;
            r_state  <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          // pready wins over the timeout limit when both land in the same cycle.
          if (pready) begin
            r_rdata   <= r_pwrite ? '0 : prdata;
            r_err     <= 1'b0;
            r_done    <= r_owner;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= APB_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_done    <= r_owner;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= APB_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_state   <= APB_IDLE;
        end
      endcase
    end
  end

  assign req_gnt   = r_gnt;
  assign rsp_done  = r_done;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_gnt;
  logic [1:0]  rsp_done;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [7:0]  paddr;
  logic        pwrite;
  logic [3:0]  psel;
  logic        penable;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;

  int tests = 0;
  int fails = 0;

  int         tb_wait  = 0;
  bit         tb_stuck = 1'b0;
  logic [7:0] tb_prdata = 8'h00;
  int         acc_cnt;

  apb_master_arbiter #(
    .N_REQ(2), .N_SLV(4), .ADDR_W(8), .DATA_W(8), .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_gnt   (req_gnt),
    .rsp_done  (rsp_done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  always #5 clk = ~clk;

  // Slave model: ready after tb_wait ACCESS cycles, never when stuck.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     acc_cnt <= 0;
    else if (penable) acc_cnt <= acc_cnt + 1;
    else              acc_cnt <= 0;
  end
  assign pready = penable && !tb_stuck && (acc_cnt == tb_wait);
  assign prdata = tb_prdata;

  task automatic drive_transfer(input string name, input int r, input bit wr,
                                input logic [7:0] addr, input logic [7:0] wdata,
                                input int wt, input bit stuck,
                                input logic [7:0] exp_rdata, input bit exp_err,
                                input logic [3:0] exp_psel, input int exp_pen);
    logic [1:0] rbit;
    int pen;
    bit unstable;
    rbit = 2'b01 << r;
    tb_wait  = wt;
    tb_stuck = stuck;
    req_write[r]       = wr;
    req_addr[r*8 +: 8] = addr;
    req_wdata[r*8 +: 8] = wdata;
    req_valid = rbit;
    @(negedge clk);
    tests++;
    if (req_gnt !== rbit) begin
      fails++; $display("FAIL %s gnt: got %b want %b", name, req_gnt, rbit);
    end
    tests++;
    if (psel !== exp_psel || penable !== 1'b0) begin
      fails++; $display("FAIL %s setup psel/penable: got %b/%b want %b/0", name, psel, penable, exp_psel);
    end
    tests++;
    if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) begin
      fails++; $display("FAIL %s setup bus: got addr %h wr %b wd %h want %h %b %h",
                        name, paddr, pwrite, pwdata, addr, wr, wdata);
    end
    req_valid = 2'b00;
    pen = 0;
    unstable = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!penable) break;
      pen++;
      if (paddr !== addr || psel !== exp_psel || pwrite !== wr || rsp_done !== 2'b00 ||
          (wr && pwdata !== wdata)) unstable = 1'b1;
    end
    tests++;
    if (pen != exp_pen) begin
      fails++; $display("FAIL %s penable cycles: got %0d want %0d", name, pen, exp_pen);
    end
    tests++;
    if (unstable) begin
      fails++; $display("FAIL %s access stability: got unstable want stable", name);
    end
    tests++;
    if (rsp_done !== rbit || rsp_err !== exp_err || rsp_rdata !== exp_rdata) begin
      fails++; $display("FAIL %s response: got done %b err %b rdata %h want %b %b %h",
                        name, rsp_done, rsp_err, rsp_rdata, rbit, exp_err, exp_rdata);
    end
    tests++;
    if (psel !== 4'b0000) begin
      fails++; $display("FAIL %s idle psel: got %b want 0000", name, psel);
    end
    @(negedge clk);
    tests++;
    if (rsp_done !== 2'b00) begin
      fails++; $display("FAIL %s done pulse width: got %b want 00", name, rsp_done);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b11;
    req_addr  = 16'hC341;
    req_wdata = 16'h5AA5;
    repeat (2) @(negedge clk);
    tests++;
    if (psel !== 4'b0000 || penable !== 1'b0) begin
      fails++; $display("FAIL reset psel/penable: got %b/%b want 0000/0", psel, penable);
    end
    tests++;
    if (req_gnt !== 2'b00 || rsp_done !== 2'b00 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL reset gnt/done/err: got %b/%b/%b want 00/00/0", req_gnt, rsp_done, rsp_err);
    end
    tests++;
    if (paddr !== 8'h00 || pwdata !== 8'h00 || pwrite !== 1'b0 || rsp_rdata !== 8'h00) begin
      fails++; $display("FAIL reset bus: got %h/%h/%b/%h want 00/00/0/00", paddr, pwdata, pwrite, rsp_rdata);
    end
    req_valid = 2'b00;
    reset_n   = 1'b1;
    @(negedge clk);
    tests++;
    if (psel !== 4'b0000 || req_gnt !== 2'b00) begin
      fails++; $display("FAIL reset idle: got psel %b gnt %b want 0000 00", psel, req_gnt);
    end
  endtask

  task automatic test_single_write();
    tb_prdata = 8'hAA;
    drive_transfer("write0", 0, 1'b1, 8'h41, 8'hA5, 0, 1'b0, 8'h00, 1'b0, 4'b0010, 1);
  endtask

  task automatic test_wait_read();
    tb_prdata = 8'h3C;
    drive_transfer("read_wait5", 1, 1'b0, 8'hC3, 8'h00, 5, 1'b0, 8'h3C, 1'b0, 4'b1000, 6);
  endtask

  task automatic test_back_to_back();
    logic [1:0] g[4];
    int n;
    bit bad;
    tb_wait  = 1;
    tb_stuck = 1'b0;
    req_write = 2'b00;
    req_addr  = 16'h8505;
    req_valid = 2'b11;
    n = 0;
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ($countones(rsp_done) > 1 || $countones(req_gnt) > 1) bad = 1'b1;
      if (req_gnt === 2'b01 && psel !== 4'b0001) bad = 1'b1;
      if (req_gnt === 2'b10 && psel !== 4'b0100) bad = 1'b1;
      if (req_gnt !== 2'b00) begin
        g[n] = req_gnt;
        n++;
        if (n == 4) begin
          req_valid = 2'b00;
          break;
        end
      end
    end
    tests++;
    if (n != 4) begin
      fails++; $display("FAIL rr grant count: got %0d want 4", n);
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL rr onehot/psel: got violation want none");
    end
    if (n == 4) begin
      tests++;
      if (g[0] !== 2'b01 || g[1] !== 2'b10 || g[2] !== 2'b01 || g[3] !== 2'b10) begin
        fails++; $display("FAIL rr order: got %b %b %b %b want 01 10 01 10", g[0], g[1], g[2], g[3]);
      end
    end
    req_valid = 2'b00;
    repeat (6) @(negedge clk);
    tests++;
    if (psel !== 4'b0000 || penable !== 1'b0) begin
      fails++; $display("FAIL rr drain: got psel %b penable %b want 0000 0", psel, penable);
    end
  endtask

  task automatic test_timeout();
    tb_prdata = 8'h5A;
    drive_transfer("timeout", 0, 1'b0, 8'h10, 8'h00, 0, 1'b1, 8'h00, 1'b1, 4'b0001, 16);
    tb_prdata = 8'h99;
    drive_transfer("after_timeout", 1, 1'b0, 8'h52, 8'h00, 2, 1'b0, 8'h99, 1'b0, 4'b0010, 3);
  endtask

  task automatic test_wait_sweep();
    int         waits[4] = '{0, 1, 3, 5};
    logic [7:0] wa[4]    = '{8'h00, 8'h47, 8'h8E, 8'hFF};
    logic [3:0] wp[4]    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] wd[4]    = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] ra[4]    = '{8'hD1, 8'h9A, 8'h63, 8'h2C};
    logic [3:0] rp[4]    = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [7:0] rd[4]    = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    for (int i = 0; i < 4; i++) begin
      tb_prdata = 8'hFF;
      drive_transfer($sformatf("sweep_wr%0d", waits[i]), i % 2, 1'b1, wa[i], wd[i],
                     waits[i], 1'b0, 8'h00, 1'b0, wp[i], waits[i] + 1);
      tb_prdata = rd[i];
      drive_transfer($sformatf("sweep_rd%0d", waits[i]), (i + 1) % 2, 1'b0, ra[i], 8'h00,
                     waits[i], 1'b0, rd[i], 1'b0, rp[i], waits[i] + 1);
    end
  endtask

  task automatic test_reset_mid_access();
    tb_wait   = 3;
    tb_stuck  = 1'b0;
    req_write = 2'b01;
    req_addr  = 16'h8080;
    req_wdata = 16'h0077;
    req_valid = 2'b01;
    @(negedge clk);
    tests++;
    if (req_gnt !== 2'b01) begin
      fails++; $display("FAIL midrst gnt: got %b want 01", req_gnt);
    end
    req_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (penable !== 1'b1 || psel !== 4'b0100) begin
      fails++; $display("FAIL midrst access: got penable %b psel %b want 1 0100", penable, psel);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (psel !== 4'b0000 || penable !== 1'b0 || rsp_done !== 2'b00 || paddr !== 8'h00) begin
      fails++; $display("FAIL midrst async: got psel %b penable %b done %b paddr %h want 0000 0 00 00",
                        psel, penable, rsp_done, paddr);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    tb_wait   = 0;
    req_write = 2'b00;
    req_addr  = 16'hC310;
    req_valid = 2'b11;
    @(negedge clk);
    tests++;
    if (req_gnt !== 2'b01 || psel !== 4'b0001) begin
      fails++; $display("FAIL midrst ptr: got gnt %b psel %b want 01 0001", req_gnt, psel);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    test_reset();
    test_single_write();
    test_wait_read();
    test_back_to_back();
    test_timeout();
    test_wait_sweep();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
